// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared formats, opcodes, NOP word and loader states
package rv_pkg;

  typedef enum logic [3:0] {
    FMT_R     = 4'd0,
    FMT_I     = 4'd1,
    FMT_L     = 4'd2,
    FMT_S     = 4'd3,
    FMT_B     = 4'd4,
    FMT_LUI   = 4'd5,
    FMT_AUIPC = 4'd6,
    FMT_JAL   = 4'd7,
    FMT_JALR  = 4'd8
  } fmt_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational field-to-RV32I word packer with illegal-format flag
module instr_pack
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = rv_pkg::NOP_WORD
) (
  input  logic [3:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the field layout for the requested format; unknown formats become a NOP
  always_comb begin
    logic [11:0] i_imm;
    word    = NOP_WORD;
    illegal = 1'b0;
    // Shift-immediate forms carry funct7 in the upper immediate bits
    if (funct3 == 3'b001 || funct3 == 3'b101) begin
      i_imm = {funct7, imm[4:0]};
    end else begin
      i_imm = imm[11:0];
    end
    case (fmt)
      FMT_R:     word = {funct7, rs2, rs1, funct3, rd, OP_R};
      FMT_I:     word = {i_imm, rs1, funct3, rd, OP_I};
      FMT_L:     word = {imm[11:0], rs1, funct3, rd, OP_L};
      FMT_JALR:  word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      FMT_S:     word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
      FMT_B:     word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
      FMT_LUI:   word = {imm[31:12], rd, OP_LUI};
      FMT_AUIPC: word = {imm[31:12], rd, OP_AUIPC};
      FMT_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default: begin
        word    = NOP_WORD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes instruction requests and streams them into IMEM from address 0
module instr_encoder_loader
  import rv_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = rv_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic              full_end;
  logic [31:0]       packed_word;
  logic              packed_illegal;
  logic              accept;
  logic              at_last_addr;

  instr_pack #(.NOP_WORD(NOP_WORD)) u_pack (
    .fmt     (in_fmt),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .imm     (in_imm),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  assign accept       = in_valid & in_ready;
  assign at_last_addr = (addr == LAST_ADDR);

  // Session state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs; a full IMEM ends the session like in_last
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (in_last || at_last_addr)) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address counter, registered write port and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      full_end   <= 1'b0;
      err        <= 1'b0;
      overflow   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= addr;
        imem_wdata <= packed_word;
        addr       <= addr + 1'b1;
        if (packed_illegal) err <= 1'b1;
        if (at_last_addr && !in_last) full_end <= 1'b1;
      end
      if (state == ST_IDLE && start) begin
        addr     <= '0;
        err      <= 1'b0;
        overflow <= 1'b0;
        full_end <= 1'b0;
      end
      // Requests arriving after the memory filled up are dropped but flagged
      if ((state == ST_FLUSH || state == ST_DONE) && full_end && in_valid) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
